// File: rtl/skp_adjust_pkg.sv
// Shared types and constants for the elastic-buffer SKP rate-matching controller.
// Optional statistics counters in skp_adjust_ctrl are enabled by SKP_ADJUST_STATS_EN.
package skp_adjust_pkg;

  // Encoded symbol width (8b/10b)
  localparam int unsigned SYM_W = 10;

  // SKP counter width; the count saturates at 7
  localparam int unsigned CNT_W = 3;

  // Default rate-matching limits
  localparam int unsigned DEF_MAX_SKP  = 5;
  localparam int unsigned DEF_MIN_SKP  = 1;
  localparam int unsigned DEF_COOLDOWN = 4;

  // K28.5 comma, both running disparities
  localparam logic [SYM_W-1:0] COM_RDN = 10'b0011111010;
  localparam logic [SYM_W-1:0] COM_RDP = 10'b1100000101;

  // K28.0 skip, both running disparities
  localparam logic [SYM_W-1:0] SKP_RDN = 10'b0011110100;
  localparam logic [SYM_W-1:0] SKP_RDP = 10'b1100001011;

  // Ordered-set tracking states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COM  = 2'd1,
    SKP  = 2'd2
  } state_t;

endpackage : skp_adjust_pkg

// File: rtl/skp_symbol_detect.sv
// Combinational COM / SKP symbol classifier covering both running disparities.
module skp_symbol_detect
  import skp_adjust_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SYM_W
) (
  input  logic [DATA_WIDTH-1:0] sym,
  input  logic                  valid,
  output logic                  is_com,
  output logic                  is_skp
);

  // A symbol only counts when the buffer actually presents valid data
  always_comb begin
    is_com = 1'b0;
    is_skp = 1'b0;
    if (valid) begin
      is_com = (sym == DATA_WIDTH'(COM_RDN)) || (sym == DATA_WIDTH'(COM_RDP));
      is_skp = (sym == DATA_WIDTH'(SKP_RDN)) || (sym == DATA_WIDTH'(SKP_RDP));
    end
  end

endmodule : skp_symbol_detect

// File: rtl/skp_adjust_ctrl.sv
// Read-side SKP rate-matching controller for the elastic buffer.
// Tracks COM/SKP ordered sets at the buffer read port and turns add/delete
// threshold requests into single-symbol insert (pointer hold) or skip
// (pointer double-advance) commands, one per ordered set, followed by a cooldown.
// Define SKP_ADJUST_STATS_EN to add saturating add_total / remove_total counters.
module skp_adjust_ctrl
  import skp_adjust_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SYM_W,
  parameter int unsigned MAX_SKP    = DEF_MAX_SKP,
  parameter int unsigned MIN_SKP    = DEF_MIN_SKP,
  parameter int unsigned COOLDOWN   = DEF_COOLDOWN
) (
  input  logic                  read_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] sym_in,
  input  logic                  sym_valid,
  input  logic                  add_req,
  input  logic                  delete_req,
  input  logic                  buffer_mode,
  output logic                  insert,
  output logic                  skip,
  output logic                  skp_added,
  output logic                  skp_removed,
  output logic [CNT_W-1:0]      skp_count,
  output logic                  os_error
`ifdef SKP_ADJUST_STATS_EN
  ,
  output logic [15:0]           add_total,
  output logic [15:0]           remove_total
`endif
);

  localparam int unsigned CD_W    = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam int unsigned CNTX_W  = CNT_W + 1;
  localparam int unsigned CNT_SAT = (1 << CNT_W) - 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CD_W-1:0]   cd_q, cd_d;
  logic              adj_q, adj_d;
  logic [CNT_W-1:0]  skp_count_d;
  logic              err_d;

  logic              is_com;
  logic              is_skp;
  logic              can_adjust;
  logic              req_conflict;
  logic [CNTX_W-1:0] cnt_after;
  logic [CNTX_W-1:0] cnt_new;
  logic [CNT_W-1:0]  cnt_sat;

  // Symbol classification at the read port
  skp_symbol_detect #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_detect (
    .sym    (sym_in),
    .valid  (sym_valid),
    .is_com (is_com),
    .is_skp (is_skp)
  );

  // Mealy insert/skip decision for the symbol currently at the port
  always_comb begin
    insert       = 1'b0;
    skip         = 1'b0;
    can_adjust   = !adj_q && (cd_q == '0);
    req_conflict = add_req && delete_req;
    // Count including the SKP at the port; the first SKP after COM is 1
    cnt_after    = (state_q == SKP) ? (CNTX_W'(cnt_q) + CNTX_W'(1)) : CNTX_W'(1);

    if (is_skp && (state_q == COM || state_q == SKP) && add_req && !req_conflict &&
        can_adjust && (cnt_after < CNTX_W'(MAX_SKP))) begin
      insert = 1'b1;
    end

    // Only from SKP, so at least MIN_SKP symbols have already gone downstream
    if (is_skp && (state_q == SKP) && (cnt_q >= CNT_W'(MIN_SKP)) && delete_req &&
        !req_conflict && !buffer_mode && can_adjust) begin
      skip = 1'b1;
    end
  end

  // Running count; a skipped SKP is never presented, so it is counted here
  always_comb begin
    cnt_new = cnt_after + (skip ? CNTX_W'(1) : CNTX_W'(0));
    cnt_sat = (cnt_new > CNTX_W'(CNT_SAT)) ? CNT_W'(CNT_SAT) : cnt_new[CNT_W-1:0];
  end

  // Next-state, counters, adjustment bookkeeping and error detection
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cd_d        = cd_q;
    adj_d       = adj_q;
    skp_count_d = skp_count;
    err_d       = os_error;

    unique case (state_q)
      IDLE: begin
        if (is_com) begin
          state_d = COM;
        end else if (is_skp) begin
          err_d = 1'b1;
        end
      end
      COM: begin
        if (is_skp) begin
          state_d = SKP;
          cnt_d   = cnt_sat;
          if (cnt_new > CNTX_W'(MAX_SKP)) err_d = 1'b1;
        end else if (is_com) begin
          state_d = COM;
        end else begin
          state_d = IDLE;
        end
      end
      SKP: begin
        if (is_skp) begin
          cnt_d = cnt_sat;
          if (cnt_new > CNTX_W'(MAX_SKP)) err_d = 1'b1;
        end else if (is_com) begin
          state_d     = COM;
          skp_count_d = cnt_q;
        end else if (sym_valid) begin
          state_d     = IDLE;
          skp_count_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every new ordered set starts fresh
    if (state_d == COM) begin
      cnt_d = '0;
      adj_d = 1'b0;
    end

    if (insert || skip) begin
      adj_d = 1'b1;
      cd_d  = CD_W'(COOLDOWN);
    end else if (cd_q != '0) begin
      cd_d = cd_q - CD_W'(1);
    end
  end

  // State and bookkeeping registers
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cd_q    <= '0;
      adj_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cd_q    <= cd_d;
      adj_q   <= adj_d;
    end
  end

  // Registered status outputs
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      skp_added   <= 1'b0;
      skp_removed <= 1'b0;
      skp_count   <= '0;
      os_error    <= 1'b0;
    end else begin
      skp_added   <= insert;
      skp_removed <= skip;
      skp_count   <= skp_count_d;
      os_error    <= err_d;
    end
  end

`ifdef SKP_ADJUST_STATS_EN
  // Saturating totals of completed insertions and deletions
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      add_total    <= '0;
      remove_total <= '0;
    end else begin
      if (skp_added && (add_total != 16'hFFFF)) begin
        add_total <= add_total + 16'd1;
      end
      if (skp_removed && (remove_total != 16'hFFFF)) begin
        remove_total <= remove_total + 16'd1;
      end
    end
  end
`endif

endmodule : skp_adjust_ctrl

// File: tb/tb_skp_adjust_ctrl.sv
// Scoreboard bench for skp_adjust_ctrl: each directed row pushes its
// hand-computed expected outputs; a monitor pops and compares on the falling edge.
module tb_skp_adjust_ctrl;

  localparam logic [9:0] C_N = 10'b0011111010;
  localparam logic [9:0] C_P = 10'b1100000101;
  localparam logic [9:0] S_N = 10'b0011110100;
  localparam logic [9:0] S_P = 10'b1100001011;
  localparam logic [9:0] DAT = 10'b1001110100;

  typedef struct packed {
    logic [15:0] id;
    logic [7:0]  val;
  } exp_t;

  logic       read_clk;
  logic       rst_n;
  logic [9:0] sym_in;
  logic       sym_valid;
  logic       add_req;
  logic       delete_req;
  logic       buffer_mode;
  logic       insert;
  logic       skip;
  logic       skp_added;
  logic       skp_removed;
  logic [2:0] skp_count;
  logic       os_error;
`ifdef SKP_ADJUST_STATS_EN
  logic [15:0] add_total;
  logic [15:0] remove_total;
`endif

  exp_t exp_q[$];
  int   checks;
  int   fails;
  int   row_id;

  skp_adjust_ctrl dut (
    .read_clk    (read_clk),
    .rst_n       (rst_n),
    .sym_in      (sym_in),
    .sym_valid   (sym_valid),
    .add_req     (add_req),
    .delete_req  (delete_req),
    .buffer_mode (buffer_mode),
    .insert      (insert),
    .skip        (skip),
    .skp_added   (skp_added),
    .skp_removed (skp_removed),
    .skp_count   (skp_count),
`ifdef SKP_ADJUST_STATS_EN
    .add_total    (add_total),
    .remove_total (remove_total),
`endif
    .os_error    (os_error)
  );

  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  // Drive one cycle of inputs just after the rising edge and queue its expectation
  task automatic row(input logic r, input logic [9:0] s, input logic v, input logic a,
                     input logic d, input logic b, input logic e_ins, input logic e_skip,
                     input logic e_add, input logic e_rem, input logic [2:0] e_cnt,
                     input logic e_err);
    exp_t t;
    @(posedge read_clk);
    #1;
    rst_n       = r;
    sym_in      = s;
    sym_valid   = v;
    add_req     = a;
    delete_req  = d;
    buffer_mode = b;
    t.id  = 16'(row_id);
    t.val = {e_ins, e_skip, e_add, e_rem, e_cnt, e_err};
    exp_q.push_back(t);
    row_id++;
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation
  initial begin
    exp_t       t;
    logic [7:0] act;
    forever begin
      @(negedge read_clk);
      if (exp_q.size() > 0) begin
        t   = exp_q.pop_front();
        act = {insert, skip, skp_added, skp_removed, skp_count, os_error};
        checks++;
        if (act !== t.val) begin
          fails++;
          $display("FAIL row %0d {insert,skip,added,removed,count[3],err}: got %b expected %b",
                   t.id, act, t.val);
        end
      end
    end
  end

  initial begin
    checks      = 0;
    fails       = 0;
    row_id      = 0;
    rst_n       = 1'b0;
    sym_in      = DAT;
    sym_valid   = 1'b0;
    add_req     = 1'b0;
    delete_req  = 1'b0;
    buffer_mode = 1'b0;

    // Reset state
    row(0, DAT, 0, 0, 0, 0,  0, 0, 0, 0, 3'd0, 0);
    row(0, DAT, 0, 0, 0, 0,  0, 0, 0, 0, 3'd0, 0);

    // Insert on first SKP; repeated SKP presented next cycle; count 4
    row(1, C_N, 1, 1, 0, 0,  0, 0, 0, 0, 3'd0, 0);
    row(1, S_N, 1, 1, 0, 0,  1, 0, 0, 0, 3'd0, 0);
    row(1, S_N, 1, 1, 0, 0,  0, 0, 1, 0, 3'd0, 0);
    row(1, S_N, 1, 1, 0, 0,  0, 0, 0, 0, 3'd0, 0);
    row(1, S_N, 1, 1, 0, 0,  0, 0, 0, 0, 3'd0, 0);
    row(1, DAT, 1, 1, 0, 0,  0, 0, 0, 0, 3'd0, 0);
    row(1, DAT, 1, 0, 0, 0,  0, 0, 0, 0, 3'd4, 0);

    // Delete on second SKP; third SKP is jumped over but counted; count 3
    row(1, C_P, 1, 0, 1, 0,  0, 0, 0, 0, 3'd4, 0);
    row(1, S_P, 1, 0, 1, 0,  0, 0, 0, 0, 3'd4, 0);
    row(1, S_P, 1, 0, 1, 0,  0, 1, 0, 0, 3'd4, 0);
    row(1, DAT, 1, 0, 1, 0,  0, 0, 0, 1, 3'd4, 0);
    row(1, DAT, 1, 0, 0, 0,  0, 0, 0, 0, 3'd3, 0);

    // Empty buffer mode: deletion never granted
    row(1, C_N, 1, 0, 1, 1,  0, 0, 0, 0, 3'd3, 0);
    row(1, S_N, 1, 0, 1, 1,  0, 0, 0, 0, 3'd3, 0);
    row(1, S_N, 1, 0, 1, 1,  0, 0, 0, 0, 3'd3, 0);
    row(1, S_N, 1, 0, 1, 1,  0, 0, 0, 0, 3'd3, 0);
    row(1, S_N, 1, 0, 1, 1,  0, 0, 0, 0, 3'd3, 0);
    row(1, DAT, 1, 0, 1, 1,  0, 0, 0, 0, 3'd3, 0);

    // Back-to-back sets: second set still in cooldown
    row(1, C_N, 1, 1, 0, 0,  0, 0, 0, 0, 3'd4, 0);
    row(1, S_N, 1, 1, 0, 0,  1, 0, 0, 0, 3'd4, 0);
    row(1, S_N, 1, 1, 0, 0,  0, 0, 1, 0, 3'd4, 0);
    row(1, DAT, 1, 1, 0, 0,  0, 0, 0, 0, 3'd4, 0);
    row(1, C_P, 1, 1, 0, 0,  0, 0, 0, 0, 3'd2, 0);
    row(1, S_P, 1, 1, 0, 0,  0, 0, 0, 0, 3'd2, 0);
    row(1, DAT, 1, 1, 0, 0,  0, 0, 0, 0, 3'd2, 0);
    row(1, DAT, 1, 0, 0, 0,  0, 0, 0, 0, 3'd1, 0);

    // Full set: no insert at cnt_after=5, sixth SKP raises os_error
    row(1, C_N, 1, 0, 0, 0,  0, 0, 0, 0, 3'd1, 0);
    row(1, S_N, 1, 0, 0, 0,  0, 0, 0, 0, 3'd1, 0);
    row(1, S_N, 1, 0, 0, 0,  0, 0, 0, 0, 3'd1, 0);
    row(1, S_N, 1, 0, 0, 0,  0, 0, 0, 0, 3'd1, 0);
    row(1, S_N, 1, 0, 0, 0,  0, 0, 0, 0, 3'd1, 0);
    row(1, S_N, 1, 1, 0, 0,  0, 0, 0, 0, 3'd1, 0);
    row(1, S_N, 1, 1, 0, 0,  0, 0, 0, 0, 3'd1, 0);
    row(1, DAT, 1, 0, 0, 0,  0, 0, 0, 0, 3'd1, 1);
    row(1, DAT, 1, 0, 0, 0,  0, 0, 0, 0, 3'd6, 1);

    // Reset mid-set while insert is high, then clean restart
    row(1, C_N, 1, 1, 0, 0,  0, 0, 0, 0, 3'd6, 1);
    row(1, S_N, 1, 1, 0, 0,  1, 0, 0, 0, 3'd6, 1);
    row(0, S_N, 1, 1, 0, 0,  0, 0, 0, 0, 3'd0, 0);
    row(1, DAT, 1, 0, 0, 0,  0, 0, 0, 0, 3'd0, 0);
    row(1, C_P, 1, 1, 0, 0,  0, 0, 0, 0, 3'd0, 0);
    row(1, S_P, 1, 1, 0, 0,  1, 0, 0, 0, 3'd0, 0);
    row(1, DAT, 1, 0, 0, 0,  0, 0, 1, 0, 3'd0, 0);
    row(1, DAT, 1, 0, 0, 0,  0, 0, 0, 0, 3'd1, 0);

    // Simultaneous add and delete requests: neither granted
    row(1, C_N, 1, 1, 1, 0,  0, 0, 0, 0, 3'd1, 0);
    row(1, S_N, 1, 1, 1, 0,  0, 0, 0, 0, 3'd1, 0);
    row(1, S_N, 1, 1, 1, 0,  0, 0, 0, 0, 3'd1, 0);
    row(1, DAT, 1, 0, 0, 0,  0, 0, 0, 0, 3'd1, 0);

    // SKP with no preceding COM sets os_error
    row(1, S_N, 1, 0, 0, 0,  0, 0, 0, 0, 3'd2, 0);
    row(1, DAT, 1, 0, 0, 0,  0, 0, 0, 0, 3'd2, 1);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge read_clk);
    @(posedge read_clk);
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

`ifdef SKP_ADJUST_STATS_EN
    checks++;
    if (add_total !== 16'd1) begin
      fails++;
      $display("FAIL add_total: got %0d expected 1", add_total);
    end
    checks++;
    if (remove_total !== 16'd0) begin
      fails++;
      $display("FAIL remove_total: got %0d expected 0", remove_total);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_skp_adjust_ctrl
